// File: rtl/ip_uart_txfifo.sv
// rtl/ip_uart_txfifo.sv - UART transmit byte FIFO with serializer handshake FSM
//
// Purpose: queues bytes written by the I/O port decode and hands them one at a
// time to a serializer through a request/busy handshake.
//
// Ports:
//   i_clk          single clock, rising edge
//   i_reset        asynchronous active-high reset
//   i_wr_en        one-cycle write strobe
//   i_wr_data      byte written when i_wr_en=1
//   i_flush        discard all queued bytes
//   i_ovf_clr      clear the sticky overflow flag
//   o_full         FIFO holds 2**DEPTH_LOG2 bytes
//   o_empty        FIFO holds 0 bytes
//   o_level        count of queued bytes, 0..2**DEPTH_LOG2
//   o_overflow     sticky: a write was dropped because the FIFO was full
//   o_send_data    byte presented to the serializer
//   o_send_req     request to the serializer
//   i_send_busy    serializer transmitting
//   o_tx_active    FSM is not in IDLE

module ip_uart_txfifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wr_en,
    input  logic [7:0]            i_wr_data,
    input  logic                  i_flush,
    input  logic                  i_ovf_clr,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_overflow,
    output logic [7:0]            o_send_data,
    output logic                  o_send_req,
    input  logic                  i_send_busy,
    output logic                  o_tx_active
);

    localparam int                DEPTH    = 2 ** DEPTH_LOG2;
    localparam int                LW       = DEPTH_LOG2 + 1;
    localparam logic [LW-1:0]     LVL_FULL = LW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [7:0]              r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [LW-1:0]           r_level;
    logic                    r_full;
    logic                    r_empty;
    logic                    r_overflow;
    logic [7:0]              r_send_data;

    logic                    w_accept;
    logic                    w_pop;
    logic                    w_ovf_set;
    logic [LW-1:0]           w_level_nxt;

    // A write is dropped only because the FIFO is full; a flush discards it
    // deliberately and therefore does not count as an overflow.
    assign w_accept  = i_wr_en && !r_full && !i_flush;
    assign w_ovf_set = i_wr_en && r_full && !i_flush;

    // The pop happens on the same edge that moves IDLE -> REQ, so only one
    // entry is consumed per serializer transaction.
    assign w_pop     = (r_state == S_IDLE) && !r_empty && !i_send_busy && !i_flush;

    always_comb begin
        w_level_nxt = r_level;
        if (i_flush) begin
            w_level_nxt = '0;
        end else begin
            w_level_nxt = r_level + LW'(w_accept) - LW'(w_pop);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_pop)        w_state_nxt = S_REQ;
            S_REQ:   if (i_send_busy)  w_state_nxt = S_DRAIN;
            S_DRAIN: if (!i_send_busy) w_state_nxt = S_IDLE;
            default:                   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Storage has no reset; pointers and level define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_overflow  <= 1'b0;
            r_send_data <= 8'h00;
        end else begin
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                // Pointer width makes the wrap to 0 implicit.
                if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LVL_FULL);
            r_empty <= (w_level_nxt == '0);

            // A new overflow wins over a simultaneous clear.
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (i_ovf_clr) begin
                r_overflow <= 1'b0;
            end

            if (w_pop) begin
                r_send_data <= r_mem[r_rd_ptr];
            end
        end
    end

    assign o_full      = r_full;
    assign o_empty     = r_empty;
    assign o_level     = r_level;
    assign o_overflow  = r_overflow;
    assign o_send_data = r_send_data;
    assign o_send_req  = (r_state == S_REQ);
    assign o_tx_active = (r_state != S_IDLE);

endmodule

// File: tb/tb_ip_uart_txfifo.sv
// tb/tb_ip_uart_txfifo.sv - self-checking bench for ip_uart_txfifo

module tb_ip_uart_txfifo;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    logic       ovf_clr;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic [7:0] send_data;
    logic       send_req;
    logic       send_busy;
    logic       tx_active;

    logic       man_busy;
    logic       auto_busy;
    logic       auto_en;
    int         ser_len;

    int         n_cmp;
    int         n_err;
    logic [7:0] exp_q[$];

    assign send_busy = man_busy | auto_busy;

    ip_uart_txfifo #(.DEPTH_LOG2(4)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_wr_en     (wr_en),
        .i_wr_data   (wr_data),
        .i_flush     (flush),
        .i_ovf_clr   (ovf_clr),
        .o_full      (full),
        .o_empty     (empty),
        .o_level     (level),
        .o_overflow  (overflow),
        .o_send_data (send_data),
        .o_send_req  (send_req),
        .i_send_busy (send_busy),
        .o_tx_active (tx_active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Serializer model: answers a request with busy held for ser_len cycles.
    initial begin
        int cnt;
        cnt = 0;
        auto_busy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (auto_en) begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) auto_busy = 1'b0;
                end else if (send_req) begin
                    auto_busy = 1'b1;
                    cnt = ser_len;
                end
            end
        end
    end

    // Scoreboard: every new request must present the next expected byte.
    initial begin
        logic       prev;
        logic [7:0] e;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (send_req && !prev) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL send_unexpected: actual=0x%0h required=no request", send_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("send_data", int'(send_data), int'(e));
                end
            end
            prev = send_req;
        end
    end

    task automatic wait_idle(input string name, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            if (!tx_active && empty && exp_q.size() == 0 && !auto_busy) done = 1'b1;
            else step();
        end
        chk(name, int'(done), 1);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic expect_accept);
        wr_en   = 1'b1;
        wr_data = d;
        if (expect_accept) exp_q.push_back(d);
        step();
        wr_en   = 1'b0;
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] data;
        logic       clr;
        logic       busy;
        logic       acc;
        int         lvl;
        logic       full;
        logic       empty;
        logic       ovf;
    } vec_t;

    vec_t vecs[20];

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Fill/overflow table: busy held so nothing drains.
        for (int k = 0; k < 16; k++) begin
            vecs[k] = '{wr: 1'b1, data: 8'(k), clr: 1'b0, busy: 1'b1, acc: 1'b1,
                        lvl: k + 1, full: (k == 15), empty: 1'b0, ovf: 1'b0};
        end
        vecs[16] = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 16, 1'b1, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 16, 1'b1, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16, 1'b1, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16, 1'b1, 1'b0, 1'b0};

        reset    = 1'b1;
        wr_en    = 1'b0;
        wr_data  = 8'h00;
        flush    = 1'b0;
        ovf_clr  = 1'b0;
        man_busy = 1'b0;
        auto_en  = 1'b0;
        ser_len  = 3;

        #12;
        chk("rst_level",     int'(level),     0);
        chk("rst_empty",     int'(empty),     1);
        chk("rst_full",      int'(full),      0);
        chk("rst_overflow",  int'(overflow),  0);
        chk("rst_send_req",  int'(send_req),  0);
        chk("rst_send_data", int'(send_data), 0);
        chk("rst_tx_active", int'(tx_active), 0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Single byte with the serializer idle.
        write_byte(8'h41, 1'b1);
        chk("sb_empty",    int'(empty),    0);
        chk("sb_level",    int'(level),    1);
        chk("sb_req_early", int'(send_req), 0);
        step();
        chk("sb_req",       int'(send_req),  1);
        chk("sb_data",      int'(send_data), 8'h41);
        chk("sb_active",    int'(tx_active), 1);
        chk("sb_empty_pop", int'(empty),     1);
        man_busy = 1'b1;
        step();
        chk("sb_req_clr",   int'(send_req),  0);
        chk("sb_drain",     int'(tx_active), 1);
        man_busy = 1'b0;
        step();
        chk("sb_idle",      int'(tx_active), 0);
        chk("sb_empty_end", int'(empty),     1);

        // Table: fill, overflow, clear-vs-set priority.
        for (int r = 0; r < 20; r++) begin
            wr_en    = vecs[r].wr;
            wr_data  = vecs[r].data;
            ovf_clr  = vecs[r].clr;
            man_busy = vecs[r].busy;
            if (vecs[r].acc) exp_q.push_back(vecs[r].data);
            step();
            chk($sformatf("tbl%0d_level", r), int'(level),    vecs[r].lvl);
            chk($sformatf("tbl%0d_full",  r), int'(full),     int'(vecs[r].full));
            chk($sformatf("tbl%0d_empty", r), int'(empty),    int'(vecs[r].empty));
            chk($sformatf("tbl%0d_ovf",   r), int'(overflow), int'(vecs[r].ovf));
            chk($sformatf("tbl%0d_req",   r), int'(send_req), 0);
            wr_en   = 1'b0;
            ovf_clr = 1'b0;
        end

        // Write while full coinciding with a pop.
        man_busy = 1'b0;
        write_byte(8'hEE, 1'b0);
        chk("sim_level", int'(level),    15);
        chk("sim_ovf",   int'(overflow), 1);
        chk("sim_full",  int'(full),     0);
        chk("sim_req",   int'(send_req), 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("sim_ovf_clr", int'(overflow), 0);
        auto_en = 1'b1;
        wait_idle("drain_fill", 400);
        auto_en = 1'b0;

        // Flush coinciding with a write while a byte is in flight.
        write_byte(8'hA1, 1'b1);
        write_byte(8'hA2, 1'b0);
        write_byte(8'hA3, 1'b0);
        chk("fl_pre_level", int'(level), 2);
        flush   = 1'b1;
        write_byte(8'hA4, 1'b0);
        flush   = 1'b0;
        chk("fl_level",   int'(level),     0);
        chk("fl_empty",   int'(empty),     1);
        chk("fl_req",     int'(send_req),  1);
        chk("fl_data",    int'(send_data), 8'hA1);
        auto_en = 1'b1;
        wait_idle("fl_complete", 50);
        chk("fl_end_level", int'(level), 0);

        // Streaming 40 bytes, pointers wrap twice.
        ser_len = 3;
        for (int i = 0; i < 40; i++) begin
            int guard;
            guard = 0;
            while (full && guard < 200) begin
                step();
                guard++;
            end
            write_byte(8'(8'h40 + i), 1'b1);
        end
        wait_idle("stream_done", 1000);
        chk("stream_ovf",   int'(overflow), 0);
        chk("stream_level", int'(level),    0);
        auto_en = 1'b0;

        // Asynchronous reset while in REQ with 5 bytes queued.
        write_byte(8'h61, 1'b1);
        for (int i = 2; i <= 6; i++) write_byte(8'(8'h60 + i), 1'b0);
        chk("rs_pre_level", int'(level),    5);
        chk("rs_pre_req",   int'(send_req), 1);
        #1;
        reset = 1'b1;
        #1;
        chk("rs_req",    int'(send_req),  0);
        chk("rs_level",  int'(level),     0);
        chk("rs_empty",  int'(empty),     1);
        chk("rs_active", int'(tx_active), 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        step();

        auto_en = 1'b1;
        write_byte(8'h5A, 1'b1);
        wait_idle("post_rst", 50);
        chk("post_rst_ovf", int'(overflow), 0);
        chk("final_queue",  exp_q.size(),   0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ip_uart_txfifo.md
IP_UART_TXFIFO -- requirements
Module: ip_uart_txfifo

Interface
REQ-001 Parameter: DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 bytes (16).
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 wr_en  input  1  one-cycle write strobe from the I/O port decode.
REQ-006 wr_data  input  8  byte written when wr_en=1.
REQ-007 flush  input  1  discard all queued bytes.
REQ-008 ovf_clr  input  1  clear the overflow flag.
REQ-009 full  output  1  FIFO holds 2**DEPTH_LOG2 bytes.
REQ-010 empty  output  1  FIFO holds 0 bytes.
REQ-011 level  output  DEPTH_LOG2+1  count of queued bytes, 0..2**DEPTH_LOG2.
REQ-012 overflow  output  1  sticky flag: a write was dropped.
REQ-013 send_data  output  8  byte presented to the serializer.
REQ-014 send_req  output  1  request to the serializer.
REQ-015 send_busy  input  1  serializer transmitting.
REQ-016 tx_active  output  1  high whenever the FSM is not in IDLE.

Function
REQ-017 Storage SHALL be a circular buffer with rd_ptr and wr_ptr of DEPTH_LOG2 bits; both pointers SHALL wrap from 2**DEPTH_LOG2-1 to 0.
REQ-018 level SHALL be a registered count: +1 on an accepted write, -1 on a pop, unchanged when both occur in one cycle.
REQ-019 full, empty and level SHALL be registered; each SHALL update one cycle after the causing edge.
REQ-020 A write SHALL be accepted only when wr_en=1, full=0 and flush=0.
REQ-021 wr_en=1 with full=1 SHALL drop the byte and set overflow, even if a pop occurs in the same cycle.
REQ-022 overflow SHALL stay set until ovf_clr=1.
REQ-023 If ovf_clr=1 and a new overflow occur in the same cycle, overflow SHALL remain set.
REQ-024 flush=1 SHALL set rd_ptr=wr_ptr=0 and level=0 in one cycle.
REQ-025 flush SHALL take priority over a simultaneous write and pop; both SHALL be discarded.
REQ-026 flush SHALL NOT affect the FSM, send_data or an in-flight send_req.
REQ-027 The FSM SHALL have three states: IDLE, REQ, DRAIN.
REQ-028 IDLE -> REQ when empty=0, send_busy=0 and flush=0; that same edge SHALL load send_data from mem[rd_ptr], pop the entry (rd_ptr+1, level-1) and set send_req=1.
REQ-029 REQ -> DRAIN when send_busy=1; that same edge SHALL clear send_req to 0.
REQ-030 DRAIN -> IDLE when send_busy=0.
REQ-031 send_data SHALL hold stable from the load edge until the next load.
REQ-032 At most one pop SHALL occur per serializer transaction.
REQ-033 Latency: write strobe at edge N -> empty=0 after N -> send_req=1 after edge N+1, provided the FSM is in IDLE and send_busy=0.
REQ-034 send_req SHALL stay high in REQ indefinitely until send_busy=1.
REQ-035 A write when level=2**DEPTH_LOG2-1 SHALL set full=1 and level=2**DEPTH_LOG2.

Reset
REQ-036 reset=1 SHALL asynchronously force: pointers=0, level=0, empty=1, full=0, overflow=0, send_req=0, send_data=8'h00, FSM=IDLE, tx_active=0.
REQ-037 Reset asserted mid-transaction SHALL abandon the queued bytes and the in-flight request.
REQ-038 After reset deasserts, the first accepted write SHALL occupy mem[0].
REQ-039 Memory contents need not be reset.

Verification
REQ-040 Single byte: write 8'h41 with serializer idle -> send_req=1 one edge later, send_data=8'h41; busy pulse 0->1->0 -> empty=1, FSM=IDLE.
REQ-041 Fill and overflow: 17 writes (8'h00..8'h10) with send_busy held 1 -> full=1 and level=16 after the 16th write; the 17th write sets overflow=1 and is dropped; on release, bytes 8'h00..8'h0F emit in order.
REQ-042 Wrap-around: 40 bytes streamed with busy = 3 cycles per byte -> all 40 emitted in order; pointers wrap twice; no overflow.
REQ-043 Simultaneous events: write with full=1 coinciding with a pop -> byte dropped, overflow=1, level=15; flush coinciding with a write -> level=0 and the in-flight byte still completes.
REQ-044 Reset: reset asserted in REQ with level=5 -> send_req=0, level=0, empty=1 immediately, without a clock edge.
